guess_event_tx: RTL and testbench

//  Input-side front end for the memory-matrix game. Conditions the raw tile switches (SW) into

---
 rtl/guess_event_tx.sv | 143 ++++++++++++++
 tb/tb_guess_event_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/guess_event_tx.sv
// rtl/guess_event_tx.sv - switch synchroniser, debouncer and single-tile guess producer
// Turns raw tile switches into one-hot guesses offered on a valid/ready handshake.
module guess_event_tx #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             enable,
   input  logic             guess_ready,
   output logic             guess_valid,
   output logic [WIDTH-1:0] guess,
   output logic             multi_error,
   output logic [7:0]       guess_count
);

   localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RELEASE,
      ST_ARMED,
      ST_OFFER,
      ST_REJECT
   } state_t;

   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_sync;
   logic [WIDTH-1:0] sw_prev;
   logic [WIDTH-1:0] sw_stable;
   logic [CNT_W-1:0] db_cnt;
   logic             settled;

   state_t           state;
   state_t           state_n;
   logic             guess_valid_n;
   logic [WIDTH-1:0] guess_n;
   logic             multi_error_n;
   logic [7:0]       guess_count_n;
   logic             stable_one_hot;

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_prev   <= '0;
         db_cnt    <= '0;
         sw_stable <= '0;
         settled   <= 1'b0;
      end else begin
         sw_meta <= sw_raw;
         sw_sync <= sw_meta;
         sw_prev <= sw_sync;
         if (sw_sync != sw_prev) begin
            db_cnt <= '0;
         end else begin
            if (db_cnt != DB_MAX)
               db_cnt <= db_cnt + CNT_W'(1);
            if (db_cnt >= DB_LAST) begin
               sw_stable <= sw_sync;
               settled   <= 1'b1;
            end
         end
      end
   end

   assign stable_one_hot = (sw_stable != '0) &&
                           ((sw_stable & (sw_stable - WIDTH'(1))) == '0);

   // settled keeps RELEASE from trusting the cleared sw_stable right after reset,
   // so a switch held through reset cannot slip out as a guess.
   always_comb begin
      state_n       = state;
      guess_valid_n = guess_valid;
      guess_n       = guess;
      multi_error_n = 1'b0;
      guess_count_n = guess_count;
      case (state)
         ST_IDLE: begin
            if (enable)
               state_n = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (settled && (sw_stable == '0))
               state_n = enable ? ST_ARMED : ST_IDLE;
         end
         ST_ARMED: begin
            if (!enable) begin
               state_n = ST_IDLE;
            end else if (sw_stable != '0) begin
               if (stable_one_hot) begin
                  state_n       = ST_OFFER;
                  guess_n       = sw_stable;
                  guess_valid_n = 1'b1;
               end else begin
                  state_n       = ST_REJECT;
                  multi_error_n = 1'b1;
               end
            end
         end
         ST_OFFER: begin
            if (guess_ready) begin
               state_n       = ST_RELEASE;
               guess_valid_n = 1'b0;
               guess_n       = '0;
               guess_count_n = guess_count + 8'd1;
            end else if (!enable) begin
               state_n       = ST_IDLE;
               guess_valid_n = 1'b0;
               guess_n       = '0;
            end
         end
         ST_REJECT: begin
            state_n = ST_RELEASE;
         end
         default: begin
            state_n       = ST_RELEASE;
            guess_valid_n = 1'b0;
            guess_n       = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RELEASE;
         guess_valid <= 1'b0;
         guess       <= '0;
         multi_error <= 1'b0;
         guess_count <= 8'd0;
      end else begin
         state       <= state_n;
         guess_valid <= guess_valid_n;
         guess       <= guess_n;
         multi_error <= multi_error_n;
         guess_count <= guess_count_n;
      end
   end

endmodule

// File: tb/tb_guess_event_tx.sv
// tb/tb_guess_event_tx.sv - directed self-checking bench for guess_event_tx
// Short debounce so every scenario, including the counter wrap, runs quickly.
module tb_guess_event_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sw_raw;
   logic       enable;
   logic       guess_ready;
   logic       guess_valid;
   logic [7:0] guess;
   logic       multi_error;
   logic [7:0] guess_count;

   int total = 0;
   int bad   = 0;
   int n;
   int nv;
   int ne;
   int wrap_miss;
   bit held_ok;

   guess_event_tx #(
      .WIDTH(8),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw_raw(sw_raw),
      .enable(enable),
      .guess_ready(guess_ready),
      .guess_valid(guess_valid),
      .guess(guess),
      .multi_error(multi_error),
      .guess_count(guess_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int maxc, output int cycles);
      cycles = 0;
      while (guess_valid !== 1'b1 && cycles < maxc) begin
         tick();
         cycles++;
      end
   endtask

   task automatic run_count(input int k, output int v_cnt, output int e_cnt);
      v_cnt = 0;
      e_cnt = 0;
      for (int i = 0; i < k; i++) begin
         tick();
         if (guess_valid === 1'b1) v_cnt++;
         if (multi_error === 1'b1) e_cnt++;
      end
   endtask

   initial begin
      reset       = 1'b1;
      sw_raw      = 8'h00;
      enable      = 1'b0;
      guess_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", {31'd0, guess_valid}, 32'd0);
      check("rst_guess", {24'd0, guess}, 32'd0);
      check("rst_merr", {31'd0, multi_error}, 32'd0);
      check("rst_count", {24'd0, guess_count}, 32'd0);

      reset       = 1'b0;
      enable      = 1'b1;
      guess_ready = 1'b1;
      run_count(12, nv, ne);

      // single guess and latency
      sw_raw = 8'h10;
      wait_valid(20, n);
      check("t1_latency_in_7_to_9", {31'd0, (n >= 7 && n <= 9)}, 32'd1);
      check("t1_guess", {24'd0, guess}, 32'h10);
      tick();
      check("t1_valid_after", {31'd0, guess_valid}, 32'd0);
      check("t1_count", {24'd0, guess_count}, 32'd1);
      run_count(20, nv, ne);
      check("t1_no_repeat", nv, 32'd0);
      sw_raw = 8'h00;
      run_count(12, nv, ne);

      // bounce rejection
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         sw_raw = ((i / 2) % 2 == 0) ? 8'h04 : 8'h00;
         tick();
         if (guess_valid === 1'b1) nv++;
      end
      run_count(15, n, ne);
      check("t2_bounce_valid", nv + n, 32'd0);
      check("t2_count", {24'd0, guess_count}, 32'd1);

      // multi-tile rejection then a legal guess
      sw_raw = 8'h03;
      run_count(15, nv, ne);
      check("t3_multi_pulses", ne, 32'd1);
      check("t3_multi_valid", nv, 32'd0);
      sw_raw = 8'h00;
      run_count(12, nv, ne);
      sw_raw = 8'h02;
      wait_valid(20, n);
      check("t3_found", {31'd0, n < 20}, 32'd1);
      check("t3_guess", {24'd0, guess}, 32'h02);
      tick();
      check("t3_count", {24'd0, guess_count}, 32'd2);
      sw_raw = 8'h00;
      run_count(12, nv, ne);

      // backpressure
      guess_ready = 1'b0;
      sw_raw      = 8'h80;
      wait_valid(20, n);
      check("t4_found", {31'd0, n < 20}, 32'd1);
      held_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (guess_valid !== 1'b1 || guess !== 8'h80) held_ok = 1'b0;
      end
      check("t4_held_stable", {31'd0, held_ok}, 32'd1);
      check("t4_count_held", {24'd0, guess_count}, 32'd2);
      guess_ready = 1'b1;
      tick();
      check("t4_valid_after", {31'd0, guess_valid}, 32'd0);
      check("t4_count", {24'd0, guess_count}, 32'd3);
      guess_ready = 1'b0;
      sw_raw      = 8'h00;
      run_count(12, nv, ne);
      sw_raw = 8'h01;
      wait_valid(20, n);
      check("t4b_guess", {24'd0, guess}, 32'h01);
      guess_ready = 1'b1;
      enable      = 1'b0;
      tick();
      check("t4b_valid", {31'd0, guess_valid}, 32'd0);
      check("t4b_count", {24'd0, guess_count}, 32'd4);
      enable      = 1'b1;
      guess_ready = 1'b0;
      sw_raw      = 8'h00;
      run_count(12, nv, ne);

      // withdraw on enable drop
      sw_raw = 8'h20;
      wait_valid(20, n);
      check("t5_guess", {24'd0, guess}, 32'h20);
      enable = 1'b0;
      tick();
      check("t5_withdraw_valid", {31'd0, guess_valid}, 32'd0);
      check("t5_withdraw_guess", {24'd0, guess}, 32'd0);
      check("t5_withdraw_count", {24'd0, guess_count}, 32'd4);
      enable = 1'b1;
      run_count(15, nv, ne);
      check("t5_held_no_guess", nv, 32'd0);
      sw_raw = 8'h00;
      run_count(12, nv, ne);

      // reset mid-offer with the switch held through it
      sw_raw = 8'h40;
      wait_valid(20, n);
      check("t5r_guess", {24'd0, guess}, 32'h40);
      reset = 1'b1;
      tick();
      check("t5r_valid", {31'd0, guess_valid}, 32'd0);
      check("t5r_guess_clr", {24'd0, guess}, 32'd0);
      check("t5r_count", {24'd0, guess_count}, 32'd0);
      reset       = 1'b0;
      guess_ready = 1'b1;
      run_count(20, nv, ne);
      check("t5r_held_no_guess", nv, 32'd0);
      sw_raw = 8'h00;
      run_count(12, nv, ne);
      sw_raw = 8'h08;
      wait_valid(20, n);
      check("t5r_next_guess", {24'd0, guess}, 32'h08);
      tick();
      check("t5r_next_count", {24'd0, guess_count}, 32'd1);
      sw_raw = 8'h00;
      run_count(12, nv, ne);

      // counter wrap
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run_count(12, nv, ne);
      wrap_miss = 0;
      for (int g = 0; g < 256; g++) begin
         sw_raw = 8'h01;
         wait_valid(20, n);
         if (n >= 20) wrap_miss++;
         tick();
         sw_raw = 8'h00;
         run_count(12, nv, ne);
         if (g == 254) check("t6_count_255", {24'd0, guess_count}, 32'd255);
      end
      check("t6_all_offered", wrap_miss, 32'd0);
      check("t6_wrap_zero", {24'd0, guess_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
